// File: rtl/membus_sram_responder_pkg.sv
// Shared MemBus types for the SRAM responder: request/response beats, FSM states
// and the response pipeline entry.
package meminf;

    typedef logic [31:0] Addr;
    typedef logic [31:0] UInt32;

    typedef struct packed {
        logic  valid;
        Addr   addr;
        logic  wen;
        UInt32 wdata;
    } MemBusReq;

    typedef struct packed {
        logic  valid;
        logic  error;
        Addr   addr;
        UInt32 rdata;
    } MemBusResp;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } MembusRespState;

    typedef struct packed {
        logic  valid;
        logic  error;
        Addr   addr;
        UInt32 rdata;
    } MembusRespStage;

    function automatic logic is_misaligned(Addr a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/membus_sram_responder_if.sv
// MemBus request/response bundle between an initiator (master) and the SRAM
// responder (slave).
interface membus_sram_responder_if;
    import meminf::*;

    // A request transfers in a cycle where req_valid && req_ready; the initiator holds
    // req_* stable while req_valid is high and ready is low. Responses have no ready.
    logic  req_valid;
    logic  req_ready;
    Addr   req_addr;
    logic  req_wen;
    UInt32 req_wdata;

    logic  resp_valid;
    logic  resp_error;
    Addr   resp_addr;
    UInt32 resp_rdata;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata,
        input  req_ready, resp_valid, resp_error, resp_addr, resp_rdata
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata,
        output req_ready, resp_valid, resp_error, resp_addr, resp_rdata
    );

endinterface

// File: rtl/membus_sram_responder_resp_pipe.sv
// Fixed-latency delay line for response beats; reset clears every stage so no
// in-flight response survives a reset.
module membus_resp_pipe
    import meminf::*;
#(
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  MembusRespStage stage_in,
    output MembusRespStage stage_out
);

    MembusRespStage stages_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages_q[i] <= '0;
            end
        end else begin
            stages_q[0] <= stage_in;
            for (int i = 1; i < LATENCY; i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign stage_out = stages_q[LATENCY-1];

endmodule

// File: rtl/membus_sram_responder.sv
// MemBus responder backed by an internal word SRAM, zero-filled after every reset.
// Optional upper-address bounds check: define MEMBUS_RESP_BOUNDS_CHECK_EN.
module membus_sram_responder
    import meminf::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    membus_sram_responder_if.slave        bus,
    output MembusRespState                dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IDX_W = (DEPTH_LOG2 > 10) ? DEPTH_LOG2 : 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    MembusRespState         state_q;
    logic [IDX_W-1:0]       init_idx_q;
    logic                   ready_q;

    UInt32                  mem [DEPTH];
    logic                   mem_we;
    logic [DEPTH_LOG2-1:0]  mem_waddr;
    UInt32                  mem_wdata;

    MemBusReq               req;
    MemBusResp              resp;
    logic                   hs;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   req_err;
    logic [DEPTH_LOG2-1:0]  req_idx;
    MembusRespStage         stage_in;
    MembusRespStage         stage_out;

    assign req = '{valid: bus.req_valid, addr: bus.req_addr,
                   wen: bus.req_wen, wdata: bus.req_wdata};

    assign hs         = req.valid && ready_q;
    assign req_idx    = req.addr[DEPTH_LOG2+1:2];
    assign misaligned = is_misaligned(req.addr);

`ifdef MEMBUS_RESP_BOUNDS_CHECK_EN
    assign out_of_range = (req.addr >> (DEPTH_LOG2 + 2)) != '0;
`else
    assign out_of_range = 1'b0;
`endif

    assign req_err = misaligned || out_of_range;

    // Init walks every word once, then ready stays high until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (init_idx_q == LAST_IDX) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        init_idx_q <= init_idx_q + 1'b1;
                    end
                end
                S_RUN: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_idx;
        mem_wdata = req.wdata;
        if (state_q == S_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_idx_q[DEPTH_LOG2-1:0];
            mem_wdata = '0;
        end else if (hs && req.wen && !req_err) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // A write from the previous cycle has already landed, so the direct read is current.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = hs;
        stage_in.error = req_err;
        stage_in.addr  = req.addr;
        if (!req_err) begin
            stage_in.rdata = req.wen ? req.wdata : mem[req_idx];
        end
    end

    membus_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .stage_in  (stage_in),
        .stage_out (stage_out)
    );

    assign resp = stage_out;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp.valid;
    assign bus.resp_error = resp.error;
    assign bus.resp_addr  = resp.addr;
    assign bus.resp_rdata = resp.rdata;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_membus_sram_responder.sv
// Bench for membus_sram_responder: directed table, back-to-back and reset sequences,
// and a random stream checked cycle by cycle against a word-array/queue model.
module tb_membus_sram_responder;
    import meminf::*;

    localparam int DEPTH_LOG2 = 4;
    localparam int LATENCY    = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int RESP_W     = 66;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    MembusRespState dbg_state;

    membus_sram_responder_if bus();

    membus_sram_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_since_rst = 0;

    logic [31:0]       model_mem [DEPTH];
    logic [RESP_W-1:0] exp_q [$];

    logic        obs_valid;
    logic        obs_error;
    logic [31:0] obs_addr;
    logic [31:0] obs_rdata;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_error;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        logic e;
        e = (a[1:0] != 2'b00);
`ifdef MEMBUS_RESP_BOUNDS_CHECK_EN
        if ((a >> (DEPTH_LOG2 + 2)) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    // One clock cycle: drive, check the beat due now, predict this cycle's acceptance.
    task automatic step(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d);
        logic              exp_ready;
        logic              err;
        logic [31:0]       rd;
        logic [RESP_W-1:0] head;
        logic [RESP_W-1:0] entry;
        int                idx;
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_wen   = w;
        bus.req_wdata = d;
        exp_ready = (cyc_since_rst >= DEPTH);
        @(negedge clk);
        check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        obs_valid = bus.resp_valid;
        obs_error = bus.resp_error;
        obs_addr  = bus.resp_addr;
        obs_rdata = bus.resp_rdata;
        head = exp_q.pop_front();
        check("resp_valid", 32'(obs_valid), 32'(head[65]));
        if (head[65]) begin
            check("resp_error", 32'(obs_error), 32'(head[64]));
            check("resp_addr", obs_addr, head[63:32]);
            check("resp_rdata", obs_rdata, head[31:0]);
        end
        entry = '0;
        if (v && exp_ready) begin
            err = model_err(a);
            idx = int'(a[DEPTH_LOG2+1:2]);
            rd  = err ? 32'h0 : (w ? d : model_mem[idx]);
            if (w && !err) model_mem[idx] = d;
            entry = {1'b1, err, a, rd};
        end
        exp_q.push_back(entry);
        @(posedge clk);
        #1;
        cyc_since_rst++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Entered and left just after a rising edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wen   = 1'b0;
        bus.req_wdata = '0;
        #1;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_error", 32'(bus.resp_error), 32'h0);
        check("rst_resp_addr", bus.resp_addr, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < LATENCY; i++) exp_q.push_back('0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        cyc_since_rst = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic        w;
        int          reads;

        vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0014, 32'h600D_CAFE, 1'b0, 32'h600D_CAFE});
        vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         1'b0, 32'h600D_CAFE});
        vecs.push_back('{1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0007, 32'h0000_0055, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0});
`ifdef MEMBUS_RESP_BOUNDS_CHECK_EN
        vecs.push_back('{1'b1, 32'h0000_0040, 32'h0000_1234, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0});
`else
        vecs.push_back('{1'b1, 32'h0000_0040, 32'h0000_1234, 1'b0, 32'h0000_1234});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_1234});
`endif
        vecs.push_back('{1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5});
        vecs.push_back('{1'b0, 32'h0000_003C, 32'h0,         1'b0, 32'hA5A5_A5A5});

        @(posedge clk);
        #1;
        apply_reset();

        // Requests offered throughout init must be ignored.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0000_0008, 1'b0, 32'h0);

        // Back-to-back write then read of the same word.
        step(1'b1, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_0010, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        check("b2b_wr_valid", 32'(obs_valid), 32'h1);
        check("b2b_wr_rdata", obs_rdata, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        check("b2b_rd_valid", 32'(obs_valid), 32'h1);
        check("b2b_rd_rdata", obs_rdata, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        check("b2b_after_valid", 32'(obs_valid), 32'h0);

        foreach (vecs[k]) begin
            step(1'b1, vecs[k].addr, vecs[k].wen, vecs[k].wdata);
            idle(LATENCY);
            check($sformatf("vec%0d_valid", k), 32'(obs_valid), 32'h1);
            check($sformatf("vec%0d_error", k), 32'(obs_error), 32'(vecs[k].exp_error));
            check($sformatf("vec%0d_addr", k), obs_addr, vecs[k].addr);
            check($sformatf("vec%0d_rdata", k), obs_rdata, vecs[k].exp_rdata);
        end

        // Random stream with idle gaps; the model checks every cycle's beat.
        reads = 0;
        while (reads < 20) begin
            if ($urandom_range(0, 2) == 0) begin
                idle(1);
            end else begin
                a = 32'($urandom_range(0, DEPTH - 1)) << 2;
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << (DEPTH_LOG2 + 2));
                w = ($urandom_range(0, 3) == 0);
                step(1'b1, a, w, $urandom);
                if (!w) reads++;
            end
        end
        idle(LATENCY);

        // Reset with two reads in flight: nothing may emerge, init restarts.
        step(1'b1, 32'h0000_0010, 1'b0, 32'h0);
        step(1'b1, 32'h0000_003C, 1'b0, 32'h0);
        apply_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0000_0010, 1'b0, 32'h0);
        step(1'b1, 32'h0000_0010, 1'b0, 32'h0);
        idle(LATENCY);
        check("post_rst_rd_valid", 32'(obs_valid), 32'h1);
        check("post_rst_rd_rdata", obs_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/membus_sram_responder.md
# membus_sram_responder

Responder end of the MemBus request/response protocol. Accepts `MemBusReq` beats from an initiator (cache refill/writeback path, MMIO bridge, or testbench), services them against an internal word-addressed SRAM, and returns `MemBusResp` beats after a fixed pipeline latency. It is the memory-side terminus for simulation and FPGA builds, replacing an external DRAM controller.

## Interface
Parameters:
- `DEPTH_LOG2`, default 12: SRAM holds 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`; legal range 1..8.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept this cycle.
- `req_addr`  in  `basic::Addr`  byte address.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_wdata`  in  32  write data (`UInt32`).
- `resp_valid`  out  1  response beat; no backpressure (MemBusResp has no ready).
- `resp_error`  out  1  request faulted.
- `resp_addr`  out  `basic::Addr`  echo of accepted `req_addr`.
- `resp_rdata`  out  32  read data.

## Operation
- FSM: `S_INIT` -> `S_RUN`.
- `S_INIT`: entered on reset; 10-bit-or-wider counter `init_idx` walks 0..2^DEPTH_LOG2-1, writing 0 each cycle; `req_ready`=0. After last index -> `S_RUN`.
- `S_RUN`: `req_ready`=1 every cycle. Handshake = `req_valid && req_ready`.
- On handshake: word index = `req_addr[DEPTH_LOG2+1:2]`.
  - Misaligned (`req_addr[1:0]` != 0): error; no SRAM write.
  - Write, no error: SRAM[index] <= `req_wdata` in the acceptance cycle; response `rdata` = `req_wdata`.
  - Read, no error: `rdata` = SRAM[index] as of the acceptance cycle, including a write accepted in the immediately preceding cycle (no stale read).
  - Error responses: `rdata` = 0.
- Response pipeline: LATENCY-deep shift register of {valid, error, addr, rdata}; one request per cycle sustained, responses strictly in acceptance order.
- No handshake in a cycle inserts a bubble (valid=0) into the pipeline.

## Timing
- Reset values: `req_ready`=0, `resp_valid`=0, `resp_error`=0, `resp_addr`=0, `resp_rdata`=0, FSM=`S_INIT`, `init_idx`=0, all pipeline valids 0.
- Init duration: exactly 2^DEPTH_LOG2 cycles after reset release; first `req_ready`=1 in cycle 2^DEPTH_LOG2.
- Request accepted in cycle t -> `resp_valid`=1 in cycle t+LATENCY, for one cycle.
- Throughput: 1 request/cycle; back-to-back write then read of same address returns the written value.
- Reset asserted mid-operation: in-flight responses dropped, outputs return to reset values asynchronously, init restarts from 0.
- `resp_*` fields other than `resp_valid` are don't-care when `resp_valid`=0, but must be registered (no combinational path from `req_*`).

## Configuration
- `MEMBUS_RESP_BOUNDS_CHECK_EN` defined: any nonzero bit of `req_addr` above bit DEPTH_LOG2+1 flags error; no write, `rdata`=0.
- Undefined: upper address bits ignored; addresses alias modulo 2^(DEPTH_LOG2+2) bytes. Misalignment error exists in both builds.

## Structure
- `meminf` package: reuse `MemBusReq`/`MemBusResp`; add `MembusRespState` enum {`S_INIT`, `S_RUN`} and a packed `MembusRespStage` struct {valid, error, addr, rdata} for pipeline entries.
- One sub-module: `membus_resp_pipe` — parameterized LATENCY-stage delay line of `MembusRespStage` with async active-low reset clearing valids.
- SRAM as inferred array in top module; single write port, read via combinational index captured into stage 0.

## Test plan
- Reset, DEPTH_LOG2=4: `req_ready` stays 0 for 16 cycles, rises in cycle 16; read of 0x8 returns rdata=0, error=0, at t+LATENCY.
- Write 0xDEADBEEF to 0x10 in cycle t, read 0x10 in t+1 -> responses at t+2 (rdata 0xDEADBEEF) and t+3 (rdata 0xDEADBEEF), LATENCY=2.
- Read 0x6 (misaligned) -> resp_error=1, rdata=0, resp_addr=0x6; SRAM unchanged.
- With `MEMBUS_RESP_BOUNDS_CHECK_EN`, DEPTH_LOG2=4: write 0x40 -> error=1; without macro, write 0x40 of 0x1234 then read 0x0 -> 0x1234.
- Stream 20 back-to-back reads with idle gaps -> responses in order, exact gaps preserved, each exactly LATENCY cycles later.
- Assert `rst_n` low with 2 requests in flight -> no `resp_valid` appears; init restarts, `req_ready`=0 for 2^DEPTH_LOG2 cycles.
